// File: rtl/cnn_window_gen.sv
// -----------------------------------------------------------------------------
// cnn_window_gen
//
// Sliding-window generator for the CNN kernel datapath. Takes a raster-order
// pixel stream, keeps KY-1 previous lines in line buffers and, for every
// stride-1 unpadded window position, presents a KX*KY window with a one-cycle
// valid strobe.
//
// Parameters:
//   KX, KY     window width / height (KY >= 2)
//   I_FM_BW    pixel width in bits
//   IMG_W      frame width in pixels (>= KX)
//   IMG_H      frame height in pixels (>= KY)
//
// Ports:
//   clk              clock, all logic on the rising edge
//   reset_n          synchronous active-low reset (highest priority)
//   i_soft_reset     synchronous clear, same effect as reset_n
//   i_in_pixel       raster-order input pixel
//   i_in_valid       pixel accepted whenever high (no backpressure)
//   o_ot_fmap        window; element e = ky*KX+kx at [I_FM_BW*e +: I_FM_BW],
//                    ky=0 top (oldest) row, kx=0 left (oldest) column
//   o_ot_valid       single-cycle strobe: o_ot_fmap holds a new window
//   o_ot_frame_done  single-cycle pulse alongside the last window of a frame
//
// Build option:
//   CNN_WIN_FRAME_DONE_EN  when defined, o_ot_frame_done is generated;
//                          otherwise it is tied to 0 and has no register.
// -----------------------------------------------------------------------------
module cnn_window_gen #(
  parameter int KX      = 3,
  parameter int KY      = 3,
  parameter int I_FM_BW = 8,
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_soft_reset,
  input  logic [I_FM_BW-1:0]         i_in_pixel,
  input  logic                       i_in_valid,
  output logic [KX*KY*I_FM_BW-1:0]   o_ot_fmap,
  output logic                       o_ot_valid,
  output logic                       o_ot_frame_done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_EMIT_MIN  = COL_W'(KX - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(KY - 2);

  typedef enum logic {
    S_FILL,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Window registers: [ky][kx][bit]. The packed layout places element
  // (ky,kx) at bit offset (ky*KX+kx)*I_FM_BW, which is exactly the output
  // format, so the window can be copied straight into o_ot_fmap.
  logic [KY-1:0][KX-1:0][I_FM_BW-1:0] win_q, win_d;

  logic [KX*KY*I_FM_BW-1:0] fmap_q;
  logic                     valid_q;

  logic clr;
  logic accept;
  logic col_at_last;
  logic row_at_last;
  logic emit;

  assign clr    = ~reset_n | i_soft_reset;
  assign accept = i_in_valid & ~clr;

  assign col_at_last = (col_q == COL_LAST);
  assign row_at_last = (row_q == ROW_LAST);

  // ---------------------------------------------------------------------------
  // Line buffers. Buffer 0 holds the oldest line, buffer KY-2 the line just
  // above the current one. All buffers are read and written at column col_q
  // in the same cycle, so each accepted pixel pushes the column up one line.
  // Read is asynchronous because the freshly read column feeds the window
  // shift of the very same pixel.
  // ---------------------------------------------------------------------------
  logic [KY-2:0][I_FM_BW-1:0] lb_rd;
  logic [KY-2:0][I_FM_BW-1:0] lb_wdata;
  logic [KY-1:0][I_FM_BW-1:0] col_new;

  genvar gi;
  generate
    for (gi = 0; gi < KY - 1; gi++) begin : g_lb
      logic [I_FM_BW-1:0] mem_q [IMG_W];

      assign lb_rd[gi]   = mem_q[col_q];
      assign col_new[gi] = lb_rd[gi];

      if (gi == KY - 2) begin : g_newest
        assign lb_wdata[gi] = i_in_pixel;
      end else begin : g_older
        assign lb_wdata[gi] = lb_rd[gi+1];
      end

      // Contents need no reset: rows 0..KY-2 of every frame rewrite each
      // column before any emitted window can depend on it.
      always_ff @(posedge clk) begin
        if (accept) begin
          mem_q[col_q] <= lb_wdata[gi];
        end
      end
    end
  endgenerate

  assign col_new[KY-1] = i_in_pixel;

  // ---------------------------------------------------------------------------
  // Next-state: counters, FSM, window shift, emit decision
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    emit    = 1'b0;

    if (i_in_valid) begin
      if (col_at_last) begin
        col_d = '0;
        row_d = row_at_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      case (state_q)
        S_FILL: begin
          if ((row_q == ROW_FILL_LAST) && col_at_last) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          // Only complete windows: left column must lie in the current row.
          emit = (col_q >= COL_EMIT_MIN);
          if (row_at_last && col_at_last) begin
            state_d = S_FILL;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_comb begin
    win_d = win_q;
    if (i_in_valid) begin
      for (int ky = 0; ky < KY; ky++) begin
        for (int kx = 0; kx < KX - 1; kx++) begin
          win_d[ky][kx] = win_q[ky][kx+1];
        end
        win_d[ky][KX-1] = col_new[ky];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_FILL;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      fmap_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= emit;
      // Output window only updates on a strobe so it holds between windows.
      if (emit) begin
        fmap_q <= win_d;
      end
    end
  end

  assign o_ot_fmap  = fmap_q;
  assign o_ot_valid = valid_q;

`ifdef CNN_WIN_FRAME_DONE_EN
  logic done_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      done_q <= 1'b0;
    end else begin
      done_q <= emit & row_at_last & col_at_last;
    end
  end

  assign o_ot_frame_done = done_q;
`else
  assign o_ot_frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_window_gen.sv
// -----------------------------------------------------------------------------
// tb_cnn_window_gen
//
// Directed bench for cnn_window_gen with KX=KY=3, 8-bit pixels, 4x4 frames.
// Pixel at (r,c) of a frame with base b has value b + 4*r + c, so the window
// whose top-left pixel is t contains t + 4*ky + kx at element ky*3+kx.
// -----------------------------------------------------------------------------
module tb_cnn_window_gen;

  localparam int KX      = 3;
  localparam int KY      = 3;
  localparam int I_FM_BW = 8;
  localparam int IMG_W   = 4;
  localparam int IMG_H   = 4;
  localparam int FW      = KX * KY * I_FM_BW;

`ifdef CNN_WIN_FRAME_DONE_EN
  localparam logic DONE_EN = 1'b1;
`else
  localparam logic DONE_EN = 1'b0;
`endif

  logic               clk;
  logic               reset_n;
  logic               i_soft_reset;
  logic [I_FM_BW-1:0] i_in_pixel;
  logic               i_in_valid;
  logic [FW-1:0]      o_ot_fmap;
  logic               o_ot_valid;
  logic               o_ot_frame_done;

  int           n_vec;
  int           n_err;
  int           strobes;
  logic [FW-1:0] exp_hold;

  cnn_window_gen #(
    .KX      (KX),
    .KY      (KY),
    .I_FM_BW (I_FM_BW),
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_soft_reset    (i_soft_reset),
    .i_in_pixel      (i_in_pixel),
    .i_in_valid      (i_in_valid),
    .o_ot_fmap       (o_ot_fmap),
    .o_ot_valid      (o_ot_valid),
    .o_ot_frame_done (o_ot_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FW-1:0] win_of(input int tl);
    logic [FW-1:0] w;
    w = '0;
    for (int ky = 0; ky < KY; ky++) begin
      for (int kx = 0; kx < KX; kx++) begin
        w[I_FM_BW*(ky*KX+kx) +: I_FM_BW] = 8'(tl + ky*IMG_W + kx);
      end
    end
    return w;
  endfunction

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_fmap(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, check registered outputs.
  task automatic push(input string tag, input logic v, input logic [7:0] pix,
                      input logic ev, input logic edone, input logic [FW-1:0] ef);
    i_in_valid = v;
    i_in_pixel = pix;
    @(posedge clk);
    #1;
    if (o_ot_valid === 1'b1) strobes++;
    if (ev) exp_hold = ef;
    check_bit({tag, " valid"}, o_ot_valid, ev);
    check_bit({tag, " frame_done"}, o_ot_frame_done, DONE_EN & edone);
    check_fmap({tag, " fmap"}, o_ot_fmap, exp_hold);
    $display("vec %s pix=%0d v=%b -> valid=%b done=%b fmap=%h",
             tag, pix, v, o_ot_valid, o_ot_frame_done, o_ot_fmap);
  endtask

  // Stream the first npix pixels of a frame; first_win is the hand-written
  // expectation for the window completed by pixel (2,2).
  task automatic run_frame(input string tag, input int base, input bit gapped,
                           input logic [FW-1:0] first_win, input int npix);
    int r, c;
    logic ev, ed;
    logic [FW-1:0] ef;
    strobes = 0;
    for (int idx = 0; idx < npix; idx++) begin
      r  = idx / IMG_W;
      c  = idx % IMG_W;
      ev = (r >= KY-1) && (c >= KX-1);
      ed = (r == IMG_H-1) && (c == IMG_W-1);
      ef = ((r == KY-1) && (c == KX-1)) ? first_win
                                        : win_of(base + (r-2)*IMG_W + (c-2));
      push(tag, 1'b1, 8'(base + idx), ev, ed, ef);
      if (gapped) push({tag, " gap"}, 1'b0, 8'hee, 1'b0, 1'b0, '0);
    end
    if (npix == IMG_W*IMG_H) begin
      n_vec++;
      assert (strobes == 4) else begin
        n_err++;
        $error("FAIL %s strobe_count: got %0d expected 4", tag, strobes);
      end
    end
  endtask

  task automatic apply_reset(input string tag, input bit hard, input int cycles);
    reset_n      = hard ? 1'b0 : 1'b1;
    i_soft_reset = hard ? 1'b0 : 1'b1;
    i_in_valid   = 1'b1;
    i_in_pixel   = 8'h55;
    exp_hold     = '0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check_bit({tag, " valid"}, o_ot_valid, 1'b0);
      check_bit({tag, " frame_done"}, o_ot_frame_done, 1'b0);
      check_fmap({tag, " fmap"}, o_ot_fmap, '0);
      $display("vec %s cycle %0d -> valid=%b done=%b fmap=%h",
               tag, i, o_ot_valid, o_ot_frame_done, o_ot_fmap);
    end
    reset_n      = 1'b1;
    i_soft_reset = 1'b0;
    i_in_valid   = 1'b0;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    strobes      = 0;
    exp_hold     = '0;
    reset_n      = 1'b0;
    i_soft_reset = 1'b0;
    i_in_valid   = 1'b0;
    i_in_pixel   = '0;

    // Power-on reset
    apply_reset("por", 1'b1, 2);

    // Basic continuous frame 0..15
    run_frame("basic", 0, 1'b0, 72'h0a_09_08_06_05_04_02_01_00, 16);

    // Same frame with a gap after every pixel
    run_frame("gapped", 0, 1'b1, 72'h0a_09_08_06_05_04_02_01_00, 16);

    // Back-to-back frames with no idle cycle between them
    run_frame("b2b_a", 0, 1'b0, 72'h0a_09_08_06_05_04_02_01_00, 16);
    run_frame("b2b_b", 100, 1'b0, 72'h6e_6d_6c_6a_69_68_66_65_64, 16);

    // Soft reset after pixel 7 (asserted together with i_in_valid)
    run_frame("pre_soft", 0, 1'b0, '0, 8);
    apply_reset("soft", 1'b0, 1);
    run_frame("post_soft", 0, 1'b0, 72'h0a_09_08_06_05_04_02_01_00, 16);

    // Hard reset for two cycles after some windows were emitted
    run_frame("pre_hard", 0, 1'b0, 72'h0a_09_08_06_05_04_02_01_00, 12);
    apply_reset("hard", 1'b1, 2);
    run_frame("post_hard", 20, 1'b0, 72'h1e_1d_1c_1a_19_18_16_15_14, 16);

    // Idle tail: nothing may be emitted
    push("idle", 1'b0, 8'h00, 1'b0, 1'b0, '0);
    push("idle", 1'b0, 8'h00, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
